// File: rtl/div_if.sv
`timescale 1ns/1ps
// div_if: handshake/operand bundle between the EX stage and the divider.
//   master : pipeline side, drives the request, reads result/ready/stall
//   slave  : div_ctrl side
interface div_if;
  logic        start_i;
  logic        annul_i;
  logic        signed_div_i;
  logic [31:0] opdata1_i;
  logic [31:0] opdata2_i;
  logic [63:0] result_o;
  logic        ready_o;
  logic        stallreq_o;

  modport master (
    output start_i, annul_i, signed_div_i, opdata1_i, opdata2_i,
    input  result_o, ready_o, stallreq_o
  );

  modport slave (
    input  start_i, annul_i, signed_div_i, opdata1_i, opdata2_i,
    output result_o, ready_o, stallreq_o
  );
endinterface

// File: rtl/div_ctrl.sv
`timescale 1ns/1ps
// div_ctrl: 32-bit multi-cycle restoring divider (DIV / DIVU) for the EX stage.
//   clk  : rising-edge clock
//   rst  : synchronous, active-high reset
//   bus  : div_if.slave
//     start_i/annul_i/signed_div_i/opdata1_i/opdata2_i : request (operands
//       sampled on the accept cycle only)
//     result_o   : {remainder, quotient}, nonzero only while ready_o=1
//     ready_o    : result valid (END state)
//     stallreq_o : combinational stall toward the pipeline controller
module div_ctrl (
  input  logic clk,
  input  logic rst,
  div_if.slave bus
);

  typedef enum logic [1:0] {IDLE, DIVZERO, ON, END} state_t;

  state_t      state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [64:0] acc_q, acc_d;     // {partial remainder[64:32], dividend/quotient[31:0]}
  logic [31:0] dvsr_q, dvsr_d;
  logic        qneg_q, qneg_d;   // negate quotient at the end
  logic        rneg_q, rneg_d;   // negate remainder at the end
  logic [63:0] res_q, res_d;

  // Magnitudes of the incoming operands; 0x80000000 negates to itself,
  // which is exactly its unsigned magnitude.
  logic [31:0] mag1, mag2;
  always_comb begin
    mag1 = (bus.signed_div_i && bus.opdata1_i[31]) ? -bus.opdata1_i : bus.opdata1_i;
    mag2 = (bus.signed_div_i && bus.opdata2_i[31]) ? -bus.opdata2_i : bus.opdata2_i;
  end

  // One restoring step: shift left, subtract divisor if it fits.
  // The 34-bit compare keeps the top accumulator bit in play even though a
  // well-formed remainder never sets it.
  logic [33:0] rem_sh;
  logic        qbit;
  logic [32:0] part;
  logic [64:0] step;
  logic [31:0] quo_f, rem_f;
  always_comb begin
    rem_sh = {acc_q[64:32], acc_q[31]};
    qbit   = (rem_sh >= {2'b00, dvsr_q});
    part   = qbit ? (rem_sh[32:0] - {1'b0, dvsr_q}) : rem_sh[32:0];
    step   = {part, acc_q[30:0], qbit};
    quo_f  = qneg_q ? -step[31:0] : step[31:0];
    rem_f  = rneg_q ? -part[31:0] : part[31:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      acc_q   <= '0;
      dvsr_q  <= '0;
      qneg_q  <= 1'b0;
      rneg_q  <= 1'b0;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      dvsr_q  <= dvsr_d;
      qneg_q  <= qneg_d;
      rneg_q  <= rneg_d;
      res_q   <= res_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    dvsr_d  = dvsr_q;
    qneg_d  = qneg_q;
    rneg_d  = rneg_q;
    res_d   = res_q;
    unique case (state_q)
      IDLE: begin
        if (bus.start_i && !bus.annul_i) begin
          cnt_d   = '0;
          acc_d   = {33'd0, mag1};
          dvsr_d  = mag2;
          qneg_d  = bus.signed_div_i && (bus.opdata1_i[31] ^ bus.opdata2_i[31]);
          rneg_d  = bus.signed_div_i && bus.opdata1_i[31];
          state_d = (bus.opdata2_i == 32'd0) ? DIVZERO : ON;
        end
      end
      DIVZERO: begin
        res_d   = '0;
        state_d = END;
      end
      ON: begin
        if (bus.annul_i) begin
          state_d = IDLE;
        end else begin
          acc_d = step;
          cnt_d = cnt_q + 5'd1;
          if (cnt_q == 5'd31) begin
            res_d   = {rem_f, quo_f};
            state_d = END;
          end
        end
      end
      END: begin
        if (!bus.start_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs are forced quiet while rst is high, even before the reset edge.
  always_comb begin
    bus.ready_o    = !rst && (state_q == END);
    bus.result_o   = bus.ready_o ? res_q : 64'd0;
    bus.stallreq_o = !rst && (((state_q == IDLE) && bus.start_i && !bus.annul_i) ||
                              ((state_q == ON) && !bus.annul_i) ||
                              (state_q == DIVZERO));
  end

endmodule

// File: tb/tb_div_ctrl.sv
`timescale 1ns/1ps
module tb_div_ctrl;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  div_if dif();

  div_ctrl u_dut (
    .clk (clk),
    .rst (rst),
    .bus (dif.slave)
  );

  typedef struct {
    string       name;
    logic        sgn;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] q;
    logic [31:0] r;
    logic        dz;
  } vec_t;

  vec_t vecs[11];
  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Starts at a negedge (cycle T) and returns at a negedge, FSM back in IDLE.
  task automatic run_vec(input vec_t v);
    int lat;
    int bad;
    lat = v.dz ? 2 : 33;
    bad = 0;
    dif.start_i      = 1'b1;
    dif.annul_i      = 1'b0;
    dif.signed_div_i = v.sgn;
    dif.opdata1_i    = v.a;
    dif.opdata2_i    = v.b;
    #1;
    chk({v.name, " stall@T"}, {63'd0, dif.stallreq_o}, 64'd1);
    chk({v.name, " ready@T"}, {63'd0, dif.ready_o}, 64'd0);
    for (int k = 1; k <= lat; k++) begin
      @(posedge clk);
      #1;
      // operands and sign mode wander after the accept edge
      dif.opdata1_i    = $urandom;
      dif.opdata2_i    = $urandom;
      dif.signed_div_i = ~v.sgn;
      @(negedge clk);
      if (k < lat && (dif.ready_o !== 1'b0 || dif.stallreq_o !== 1'b1 ||
                      dif.result_o !== 64'd0))
        bad++;
    end
    chk({v.name, " busy cycles"}, 64'(bad), 64'd0);
    chk({v.name, " ready@lat"}, {63'd0, dif.ready_o}, 64'd1);
    chk({v.name, " stall@lat"}, {63'd0, dif.stallreq_o}, 64'd0);
    chk({v.name, " result"}, dif.result_o, {v.r, v.q});
    @(negedge clk);
    chk({v.name, " hold result"}, {dif.ready_o, dif.result_o[62:0]}, {1'b1, v.r[30:0], v.q});
    dif.start_i = 1'b0;
    @(negedge clk);
    chk({v.name, " back idle"}, {dif.ready_o, dif.stallreq_o, dif.result_o[61:0]}, 64'd0);
  endtask

  initial begin
    vecs[0]  = '{"divu 100/7",      1'b0, 32'd100,      32'd7,        32'h0000000E, 32'h00000002, 1'b0};
    vecs[1]  = '{"div -100/7",      1'b1, 32'hFFFFFF9C, 32'd7,        32'hFFFFFFF2, 32'hFFFFFFFE, 1'b0};
    vecs[2]  = '{"div 5/0",         1'b1, 32'd5,        32'd0,        32'h00000000, 32'h00000000, 1'b1};
    vecs[3]  = '{"div ovf",         1'b1, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 32'h00000000, 1'b0};
    vecs[4]  = '{"divu max/1",      1'b0, 32'hFFFFFFFF, 32'd1,        32'hFFFFFFFF, 32'h00000000, 1'b0};
    vecs[5]  = '{"div 100/-7",      1'b1, 32'd100,      32'hFFFFFFF9, 32'hFFFFFFF2, 32'h00000002, 1'b0};
    vecs[6]  = '{"div -100/-7",     1'b1, 32'hFFFFFF9C, 32'hFFFFFFF9, 32'h0000000E, 32'hFFFFFFFE, 1'b0};
    vecs[7]  = '{"divu big/7",      1'b0, 32'hFFFFFF9C, 32'd7,        32'h24924916, 32'h00000002, 1'b0};
    vecs[8]  = '{"divu 3/5",        1'b0, 32'd3,        32'd5,        32'h00000000, 32'h00000003, 1'b0};
    vecs[9]  = '{"divu 0/0",        1'b0, 32'd0,        32'd0,        32'h00000000, 32'h00000000, 1'b1};
    vecs[10] = '{"div min/1",       1'b1, 32'h80000000, 32'd1,        32'h80000000, 32'h00000000, 1'b0};

    // reset with a request present: outputs must stay quiet
    rst              = 1'b1;
    dif.start_i      = 1'b1;
    dif.annul_i      = 1'b0;
    dif.signed_div_i = 1'b0;
    dif.opdata1_i    = 32'd9;
    dif.opdata2_i    = 32'd3;
    repeat (3) @(negedge clk);
    chk("reset outputs", {dif.ready_o, dif.stallreq_o, dif.result_o[61:0]}, 64'd0);
    rst         = 1'b0;
    dif.start_i = 1'b0;
    @(negedge clk);
    chk("idle after reset", {dif.ready_o, dif.stallreq_o, dif.result_o[61:0]}, 64'd0);

    foreach (vecs[i]) run_vec(vecs[i]);

    // annul mid-division at T+10, restart at T+12
    dif.start_i      = 1'b1;
    dif.signed_div_i = 1'b0;
    dif.opdata1_i    = 32'd1000;
    dif.opdata2_i    = 32'd3;
    repeat (10) @(negedge clk);
    dif.annul_i = 1'b1;
    #1;
    chk("annul stall@T+10", {63'd0, dif.stallreq_o}, 64'd0);
    @(negedge clk);
    // T+11: back in IDLE; start with annul must not be accepted
    #1;
    chk("annul idle@T+11", {dif.ready_o, dif.stallreq_o, dif.result_o[61:0]}, 64'd0);
    @(negedge clk);
    chk("annul no accept", {dif.ready_o, dif.stallreq_o, dif.result_o[61:0]}, 64'd0);
    run_vec(vecs[0]);

    // reset at T+20 of a division
    dif.start_i      = 1'b1;
    dif.annul_i      = 1'b0;
    dif.signed_div_i = 1'b1;
    dif.opdata1_i    = 32'hFFFFFF9C;
    dif.opdata2_i    = 32'd7;
    repeat (20) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("mid reset outputs", {dif.ready_o, dif.stallreq_o, dif.result_o[61:0]}, 64'd0);
    rst         = 1'b0;
    dif.start_i = 1'b0;
    @(negedge clk);
    chk("after mid reset", {dif.ready_o, dif.stallreq_o, dif.result_o[61:0]}, 64'd0);
    run_vec(vecs[1]);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
